// File: rtl/matrix_stream_mult.sv
// Streaming matrix multiplier: loads a runtime (M,N,P) header plus signed byte
// matrices A and B, computes C = A*B on one shared MAC and streams C out LSB first.
module matrix_stream_mult #(
    parameter int MAX_M = 4,
    parameter int MAX_N = 4,
    parameter int MAX_P = 4,
    parameter int ACC_W = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       err
);
    localparam int RB = ACC_W / 8;
    localparam int MW = (MAX_M > 1) ? $clog2(MAX_M) : 1;
    localparam int NW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int PW = (MAX_P > 1) ? $clog2(MAX_P) : 1;
    localparam int SW = $clog2(RB);
    localparam logic [7:0] MAX_M8 = 8'(MAX_M);
    localparam logic [7:0] MAX_N8 = 8'(MAX_N);
    localparam logic [7:0] MAX_P8 = 8'(MAX_P);
    localparam logic [SW-1:0] SB_LAST = SW'(RB - 1);

    typedef enum logic [2:0] {
        HDR_M, HDR_N, HDR_P, LOAD_A, LOAD_B, COMPUTE, SEND, ERR
    } state_t;

    state_t state, state_next;

    logic [7:0] m_raw, n_raw, p_raw;
    logic [MW-1:0] m_last, ci, ni;
    logic [NW-1:0] n_last, ck;
    logic [PW-1:0] p_last, cj, nj;
    logic [SW-1:0] sb, nb;
    logic wr_phase;

    logic signed [7:0] a_mem [MAX_M][MAX_N];
    logic signed [7:0] b_mem [MAX_N][MAX_P];
    logic [ACC_W-1:0] c_mem [MAX_M][MAX_P];
    logic [ACC_W-1:0] acc, shifted;
    logic signed [15:0] a_ext, b_ext, prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic [7:0] next_byte;

    logic in_fire, out_fire, hdr_bad, last_i, last_k, last_j, last_b;

    assign m_last   = MW'(m_raw - 8'd1);
    assign n_last   = NW'(n_raw - 8'd1);
    assign p_last   = PW'(p_raw - 8'd1);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign last_i   = (ci == m_last);
    assign last_k   = (ck == n_last);
    assign last_j   = (cj == p_last);
    assign last_b   = (sb == SB_LAST);
    assign busy     = (state != HDR_M);

    // The header check sees the P byte directly, before it is registered.
    assign hdr_bad = (m_raw == 8'd0) || (n_raw == 8'd0) || (in_data == 8'd0) ||
                     (m_raw > MAX_M8) || (n_raw > MAX_N8) || (in_data > MAX_P8);

    assign a_ext    = 16'(a_mem[ci][ck]);
    assign b_ext    = 16'(b_mem[ck][cj]);
    assign prod     = a_ext * b_ext;
    assign prod_ext = ACC_W'(prod);

    always_ff @(posedge clk) begin
        if (rst) state <= HDR_M;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            HDR_M:   begin in_ready = 1'b1; if (in_valid) state_next = HDR_N; end
            HDR_N:   begin in_ready = 1'b1; if (in_valid) state_next = HDR_P; end
            HDR_P: begin
                in_ready = 1'b1;
                if (in_valid) state_next = hdr_bad ? ERR : LOAD_A;
            end
            LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid && last_i && last_k) state_next = LOAD_B;
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid && last_k && last_j) state_next = COMPUTE;
            end
            COMPUTE: if (wr_phase && last_i && last_j) state_next = SEND;
            SEND:    if (out_fire && last_b && last_i && last_j) state_next = HDR_M;
            ERR:     if (out_fire) state_next = HDR_M;
            default: state_next = HDR_M;
        endcase
    end

    // Position of the byte that follows the one currently presented in SEND.
    always_comb begin
        nb = sb + 1'b1;
        ni = ci;
        nj = cj;
        if (last_b) begin
            nb = '0;
            if (last_j) begin
                nj = '0;
                ni = last_i ? '0 : ci + 1'b1;
            end else begin
                nj = cj + 1'b1;
            end
        end
        shifted   = c_mem[ni][nj] >> {nb, 3'b000};
        next_byte = shifted[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_raw     <= '0;
            n_raw     <= '0;
            p_raw     <= '0;
            ci        <= '0;
            ck        <= '0;
            cj        <= '0;
            sb        <= '0;
            wr_phase  <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                HDR_M: if (in_fire) m_raw <= in_data;
                HDR_N: if (in_fire) n_raw <= in_data;
                HDR_P: if (in_fire) begin
                    p_raw    <= in_data;
                    ci       <= '0;
                    ck       <= '0;
                    cj       <= '0;
                    sb       <= '0;
                    wr_phase <= 1'b0;
                    acc      <= '0;
                    if (hdr_bad) begin
                        err       <= 1'b1;
                        out_valid <= 1'b1;
                        out_data  <= 8'hEE;
                    end
                end
                LOAD_A: if (in_fire) begin
                    a_mem[ci][ck] <= in_data;
                    if (last_k) begin
                        ck <= '0;
                        ci <= last_i ? '0 : ci + 1'b1;
                    end else begin
                        ck <= ck + 1'b1;
                    end
                end
                LOAD_B: if (in_fire) begin
                    b_mem[ck][cj] <= in_data;
                    if (last_j) begin
                        cj <= '0;
                        ck <= last_k ? '0 : ck + 1'b1;
                    end else begin
                        cj <= cj + 1'b1;
                    end
                end
                // N accumulate cycles per element, then one write cycle that also clears acc.
                COMPUTE: begin
                    if (!wr_phase) begin
                        acc      <= acc + prod_ext;
                        ck       <= last_k ? '0 : ck + 1'b1;
                        wr_phase <= last_k;
                    end else begin
                        c_mem[ci][cj] <= acc;
                        acc           <= '0;
                        wr_phase      <= 1'b0;
                        if (last_j) begin
                            cj <= '0;
                            ci <= last_i ? '0 : ci + 1'b1;
                        end else begin
                            cj <= cj + 1'b1;
                        end
                        if (last_i && last_j) begin
                            out_valid <= 1'b1;
                            out_data  <= (m_last == '0 && p_last == '0) ? acc[7:0]
                                                                        : c_mem[0][0][7:0];
                        end
                    end
                end
                SEND: if (out_fire) begin
                    sb <= nb;
                    ci <= ni;
                    cj <= nj;
                    if (last_b && last_i && last_j) out_valid <= 1'b0;
                    else                            out_data  <= next_byte;
                end
                ERR: if (out_fire) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_stream_mult.sv
// Bench for matrix_stream_mult: directed vector table, randomized jobs against a
// plain-arithmetic matrix model, and reset-recovery sequences.
module tb_matrix_stream_mult;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready_a, out_valid_a, busy_a, err_a;
    logic [7:0] out_data_a;
    logic       in_ready_b, out_valid_b, busy_b, err_b;
    logic [7:0] out_data_b;

    bit         sel = 1'b0;
    logic       cur_in_ready, cur_out_valid, cur_busy, cur_err;
    logic [7:0] cur_out_data;

    int total = 0;
    int bad = 0;
    logic [7:0] din_q[$];
    logic [7:0] exp_q[$];

    typedef struct packed {
        logic [7:0]   m;
        logic [7:0]   n;
        logic [7:0]   p;
        bit           w16;
        logic [127:0] din;
        int           nd;
        logic [95:0]  dexp;
        int           ne;
        int           lat;
    } vec_t;

    vec_t vec [8];

    matrix_stream_mult #(.MAX_M(4), .MAX_N(4), .MAX_P(4), .ACC_W(24)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a), .out_data(out_data_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .busy(busy_a), .err(err_a)
    );

    matrix_stream_mult #(.MAX_M(4), .MAX_N(4), .MAX_P(4), .ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .busy(busy_b), .err(err_b)
    );

    assign cur_in_ready  = sel ? in_ready_b  : in_ready_a;
    assign cur_out_valid = sel ? out_valid_b : out_valid_a;
    assign cur_out_data  = sel ? out_data_b  : out_data_a;
    assign cur_busy      = sel ? busy_b      : busy_a;
    assign cur_err       = sel ? err_b       : err_a;

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        in_data = b;
        in_valid = 1'b1;
        while (!cur_in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check_output("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input int m, input int n, input int p);
        send_byte(8'(m));
        send_byte(8'(n));
        send_byte(8'(p));
        foreach (din_q[i]) send_byte(din_q[i]);
    endtask

    // Collects exp_q.size() bytes, checking values, compute latency, err pulses and stalls.
    task automatic run_job(input int m, input int n, input int p, input bit rr,
                           input int exp_lat, input int exp_err);
        int lat = 0, got = 0, t = 0, errs = 0;
        bit seen = 0, prev_stall = 0;
        logic [7:0] prev_data = 8'h00;
        apply_stimulus(m, n, p);
        while (got < exp_q.size() && t < 5000) begin
            @(negedge clk);
            t++;
            if (cur_err) errs++;
            if (prev_stall) begin
                check_output("stall_valid", int'(cur_out_valid), 1);
                check_output("stall_data", int'(cur_out_data), int'(prev_data));
            end
            out_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cur_out_valid) begin
                seen = 1;
                if (out_ready) begin
                    check_output($sformatf("byte%0d", got), int'(cur_out_data), int'(exp_q[got]));
                    got++;
                end
            end else if (!seen) begin
                lat++;
            end
            prev_stall = cur_out_valid && !out_ready;
            prev_data = cur_out_data;
        end
        if (t >= 5000) check_output("out_timeout", got, exp_q.size());
        check_output("latency", lat, exp_lat);
        @(negedge clk);
        if (cur_err) errs++;
        check_output("err_pulses", errs, exp_err);
        check_output("idle_busy", int'(cur_busy), 0);
        check_output("idle_valid", int'(cur_out_valid), 0);
        out_ready = 1'b0;
    endtask

    // Reference: C = A*B with integer arithmetic, reduced to three little-endian bytes.
    task automatic build_random(input int m, input int n, input int p);
        int av [4][4];
        int bv [4][4];
        int s;
        logic [7:0] r;
        din_q.delete();
        exp_q.delete();
        for (int i = 0; i < m; i++)
            for (int k = 0; k < n; k++) begin
                r = 8'($urandom_range(0, 255));
                din_q.push_back(r);
                av[i][k] = int'($signed(r));
            end
        for (int k = 0; k < n; k++)
            for (int j = 0; j < p; j++) begin
                r = 8'($urandom_range(0, 255));
                din_q.push_back(r);
                bv[k][j] = int'($signed(r));
            end
        for (int i = 0; i < m; i++)
            for (int j = 0; j < p; j++) begin
                s = 0;
                for (int k = 0; k < n; k++) s += av[i][k] * bv[k][j];
                for (int b = 0; b < 3; b++) exp_q.push_back(8'((s >> (8 * b)) & 255));
            end
    endtask

    initial begin
        int m, n, p;
        bit prev_w;
        logic [127:0] dtmp;
        logic [95:0] etmp;

        vec[0] = '{m:8'd2, n:8'd2, p:8'd2, w16:1'b0,
                   din:128'h01020304_01000001_00000000_00000000, nd:8,
                   dexp:96'h010000_020000_030000_040000, ne:12, lat:12};
        vec[1] = '{m:8'd0, n:8'd2, p:8'd2, w16:1'b0, din:128'h0, nd:0,
                   dexp:96'hEE_0000000000000000000000, ne:1, lat:0};
        vec[2] = '{m:8'd5, n:8'd1, p:8'd1, w16:1'b0, din:128'h0, nd:0,
                   dexp:96'hEE_0000000000000000000000, ne:1, lat:0};
        vec[3] = '{m:8'd2, n:8'd0, p:8'd3, w16:1'b0, din:128'h0, nd:0,
                   dexp:96'hEE_0000000000000000000000, ne:1, lat:0};
        vec[4] = '{m:8'd1, n:8'd1, p:8'd5, w16:1'b0, din:128'h0, nd:0,
                   dexp:96'hEE_0000000000000000000000, ne:1, lat:0};
        vec[5] = '{m:8'd1, n:8'd1, p:8'd1, w16:1'b0,
                   din:128'h8080_0000_0000_0000_0000_0000_0000_0000, nd:2,
                   dexp:96'h004000_000000_000000_000000, ne:3, lat:2};
        vec[6] = '{m:8'd2, n:8'd3, p:8'd1, w16:1'b0,
                   din:128'h01FE03FC05FA07F809_00000000000000, nd:9,
                   dexp:96'h320000_86FFFF_000000_000000, ne:6, lat:8};
        vec[7] = '{m:8'd1, n:8'd4, p:8'd1, w16:1'b1,
                   din:128'h7F7F7F7F7F7F7F7F_0000000000000000, nd:8,
                   dexp:96'h04FC_0000_0000_0000_0000_0000, ne:2, lat:5};

        do_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check_output("rst_in_ready", int'(cur_in_ready), 1);
            check_output("rst_out_valid", int'(cur_out_valid), 0);
            check_output("rst_out_data", int'(cur_out_data), 0);
            check_output("rst_busy", int'(cur_busy), 0);
            check_output("rst_err", int'(cur_err), 0);
        end

        prev_w = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (vec[i].w16 != prev_w) begin
                sel = vec[i].w16;
                do_reset();
            end
            prev_w = vec[i].w16;
            dtmp = vec[i].din;
            etmp = vec[i].dexp;
            din_q.delete();
            exp_q.delete();
            for (int b = 0; b < vec[i].nd; b++) din_q.push_back(dtmp[127 - 8 * b -: 8]);
            for (int b = 0; b < vec[i].ne; b++) exp_q.push_back(etmp[95 - 8 * b -: 8]);
            run_job(int'(vec[i].m), int'(vec[i].n), int'(vec[i].p), 1'b0,
                    vec[i].lat, (vec[i].nd == 0) ? 1 : 0);
        end

        sel = 1'b0;
        do_reset();
        for (int r = 0; r < 8; r++) begin
            if (r == 0) begin
                m = 3; n = 4; p = 2;
            end else begin
                m = $urandom_range(1, 4); n = $urandom_range(1, 4); p = $urandom_range(1, 4);
            end
            build_random(m, n, p);
            run_job(m, n, p, (r % 3) != 2, m * p * (n + 1), 0);
        end

        din_q.delete();
        exp_q.delete();
        exp_q.push_back(8'hEE);
        run_job($urandom_range(5, 255), 2, 2, 1'b1, 0, 1);

        // Reset in the middle of LOAD_B, then a fresh 1x1x1 job.
        build_random(2, 2, 2);
        send_byte(8'd2); send_byte(8'd2); send_byte(8'd2);
        for (int i = 0; i < 5; i++) send_byte(din_q[i]);
        do_reset();
        check_output("rstB_busy", int'(cur_busy), 0);
        check_output("rstB_in_ready", int'(cur_in_ready), 1);
        din_q = '{8'd3, 8'd5};
        exp_q = '{8'h0F, 8'h00, 8'h00};
        run_job(1, 1, 1, 1'b0, 2, 0);

        // Reset while a result byte is pending with out_ready low.
        build_random(2, 2, 2);
        apply_stimulus(2, 2, 2);
        out_ready = 1'b0;
        for (int t = 0; t < 100 && !cur_out_valid; t++) @(negedge clk);
        check_output("pend_valid", int'(cur_out_valid), 1);
        repeat (3) @(negedge clk);
        do_reset();
        check_output("rstS_valid", int'(cur_out_valid), 0);
        check_output("rstS_data", int'(cur_out_data), 0);
        check_output("rstS_busy", int'(cur_busy), 0);
        din_q = '{8'd2, 8'd3};
        exp_q = '{8'h06, 8'h00, 8'h00};
        run_job(1, 1, 1, 1'b0, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
